rv32_divider: RTL
=================

# rv32_divider

Multi-cycle integer divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the subtractive counterpart to the single-cycle datapath adder. It sits beside the ALU in the execute stage. The core stalls on `busy` and captures `result` on `done`. Division uses a restoring shift-subtract loop, one quotient bit per clock.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a division; sampled only when `busy`=0.
- `op`, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with `start`.
- `a`, input, WIDTH: dividend; latched with `start`.
- `b`, input, WIDTH: divisor; latched with `start`.
- `busy`, output, 1: an operation is in flight; new `start` is ignored.
- `done`, output, 1: one-cycle pulse; `result` is valid.
- `result`, output, WIDTH: quotient or remainder; held until the next accepted `start`.

## Operation
- States are IDLE, CALC and FIN. The reset state is IDLE.
- **IDLE**, on `start`=1:
  - Latch `op`, `a` and `b`.
  - For signed ops (DIV, REM), convert both operands to magnitudes. Record `q_neg` = sign(a) XOR sign(b) and `r_neg` = sign(a).
  - Clear the partial remainder (WIDTH+1 bits). Load the quotient register with |a|. Set the iteration counter to WIDTH.
  - Go to CALC.
- **CALC**, each cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − |b| at WIDTH+1 bits.
  - If trial ≥ 0, rem ← trial and quotient LSB ← 1. Otherwise rem is kept and the LSB ← 0.
  - Decrement the counter. After the WIDTH-th iteration, go to FIN.
- **FIN**:
  - Apply the signs: quotient is negated if `q_neg`; remainder is negated if `r_neg`.
  - Select `result`: quotient for op 00/01, remainder for op 10/11.
  - Pulse `done`, then go to IDLE.
- **Divide by zero** (b = 0):
  - DIV and DIVU return all-ones (0xFFFFFFFF).
  - REM and REMU return `a` unchanged.
  - No exception is raised. Latency is the same as a normal divide.
- **Signed overflow** (DIV with a = 0x80000000, b = 0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
  - Latency is the same as a normal divide.
- Special cases are detected at `start` and override the FIN result. The loop still runs, so latency stays fixed.
- `start` while `busy`=1 has no effect and does not corrupt the latched operands.
- All arithmetic is two's complement. The magnitude of 0x80000000 is 0x80000000 held as unsigned.

## Timing
- All outputs reset to 0: `busy`=0, `done`=0, `result`=0. The state goes to IDLE.
- Reset is asynchronous. Asserting `rst_n` low mid-operation aborts immediately; no `done` is produced for the aborted op.
- Edge-by-edge sequence:
  - Start is accepted at edge T0. `busy`=1 from T0.
  - CALC iterations occur at edges T1..T32.
  - FIN registers `result` and `done`=1 at edge T33, and `busy` falls at T33.
  - `done` drops at T34.
  - Fixed latency: 33 cycles from acceptance to `done`.
- `start` may be asserted in the same cycle `done`=1 (busy=0). It is accepted at T34, and `result` stays stable until the new op's FIN.
- Back-to-back throughput is one op per 34 cycles.

## Test plan
- DIVU a=1010, b=101: `done` exactly 33 cycles after acceptance, `result`=10. Same operands with REMU: `result`=0.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). REMU a=7, b=0xFFFFFFFE → 7.
- DIVU a=1010, b=0 → 0xFFFFFFFF. REMU a=1010, b=0 → 1010. DIV a=−5, b=0 → 0xFFFFFFFF. All with normal latency.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Assert `start` with new operands at cycle 10 of a DIVU 100/7 → ignored; result 14. Then issue a new `start` during the `done` cycle → accepted; its result appears 33 cycles later.
- Pulse `rst_n` low at cycle 15 of an operation → `busy`, `done` and `result` read 0 immediately, no `done` pulse follows, and the next op completes correctly.

Source files
------------

// File: rtl/rv32_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring shift-subtract, one
// quotient bit per clock, fixed 33-cycle latency from accepted start to done.
module rv32_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, dz, ovf;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_fin, r_fin, res_fin;

    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
        // rem < dvs always, so its low WIDTH bits hold the whole value
        shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial     = shifted - {1'b0, dvs};
        q_fin     = q_neg ? (~quo + 1'b1) : quo;
        r_fin     = r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        if (dz)
            res_fin = op_q[1] ? a_q : {WIDTH{1'b1}};
        else if (ovf)
            res_fin = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        else
            res_fin = op_q[1] ? r_fin : q_fin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        dvs   <= b_mag;
                        rem   <= '0;
                        quo   <= a_mag;
                        cnt   <= CW'(WIDTH);
                        q_neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg <= signed_op & a[WIDTH-1];
                        dz    <= (b == '0);
                        ovf   <= signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (b == {WIDTH{1'b1}});
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIN;
                end
                FIN: begin
                    result <= res_fin;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
